// File: rtl/temp_uart_framer_pkg.sv
// Shared definitions for the temperature-to-UART framer.
// Holds the FSM encoding, the ASCII bytes used in a frame, and the byte mux.
package temp_uart_framer_pkg;

  // Bytes per frame: sign, three digits, '.', tenths, 'C', CR, LF.
  localparam int FRAME_LEN = 9;

  // Number of shift-add-3 iterations for a 7-bit integer part.
  localparam int BCD_STEPS = 7;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_CONV    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WAIT_LO = 3'd5
  } state_e;

  // Selects the ASCII byte at a given position of the frame.
  function automatic logic [7:0] frame_byte(
    input logic [3:0] idx,
    input logic       neg,
    input logic [3:0] hun,
    input logic [3:0] ten,
    input logic [3:0] uni,
    input logic [3:0] tenths
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = neg ? ASCII_MINUS : ASCII_PLUS;
      4'd1:    b = ASCII_ZERO + {4'd0, hun};
      4'd2:    b = ASCII_ZERO + {4'd0, ten};
      4'd3:    b = ASCII_ZERO + {4'd0, uni};
      4'd4:    b = ASCII_DOT;
      4'd5:    b = ASCII_ZERO + {4'd0, tenths};
      4'd6:    b = ASCII_C;
      4'd7:    b = ASCII_CR;
      4'd8:    b = ASCII_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/temp_uart_framer_bin2bcd_seq.sv
// Sequential 7-bit binary to 3-digit BCD converter (shift-add-3).
// start_i loads the operand; one iteration runs per cycle afterwards.
// done_o is high in the cycle the final iteration is taken, so the
// digit outputs are valid from the following cycle and stay stable
// until the next start_i.
module bin2bcd_seq
  import temp_uart_framer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [6:0] bin_i,
  output logic       done_o,
  output logic [3:0] hun_o,
  output logic [3:0] ten_o,
  output logic [3:0] uni_o
);

  localparam logic [2:0] LAST_STEP = 3'(BCD_STEPS - 1);

  logic [11:0] bcd_q, bcd_d;
  logic [6:0]  bin_q, bin_d;
  logic [2:0]  step_q, step_d;
  logic        run_q, run_d;
  logic [11:0] adj;

  genvar gi;

  // Add 3 to every BCD digit that is 5 or more before the shift.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_add3
      assign adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? (bcd_q[gi*4 +: 4] + 4'd3)
                                                          : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // Next-state: load on start, otherwise one adjust-and-shift per cycle while running.
  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    step_d = step_q;
    run_d  = run_q;
    if (start_i) begin
      bcd_d  = 12'd0;
      bin_d  = bin_i;
      step_d = 3'd0;
      run_d  = 1'b1;
    end else if (run_q) begin
      bcd_d  = {adj[10:0], bin_q[6]};
      bin_d  = {bin_q[5:0], 1'b0};
      step_d = step_q + 3'd1;
      if (step_q == LAST_STEP) begin
        run_d = 1'b0;
      end
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q  <= 12'd0;
      bin_q  <= 7'd0;
      step_q <= 3'd0;
      run_q  <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      step_q <= step_d;
      run_q  <= run_d;
    end
  end

  assign done_o = run_q && (step_q == LAST_STEP);
  assign hun_o  = bcd_q[11:8];
  assign ten_o  = bcd_q[7:4];
  assign uni_o  = bcd_q[3:0];

endmodule

// File: rtl/temp_uart_framer.sv
// Periodic DS18B20 temperature framer: once per period it snapshots the
// raw reading, converts it to "+DDD.TC\r\n" and hands the bytes one at a
// time to a uart_tx using a vld / busy handshake. Ticks that arrive while
// a frame is in progress are counted in a saturating drop counter.
module temp_uart_framer #(
  parameter int PERIOD_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] t_data,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  output logic        frame_busy,
  output logic [7:0]  drop_cnt
);

  // Frame length is fixed by the byte format.
  localparam int FRAME_LEN = temp_uart_framer_pkg::FRAME_LEN;

  import temp_uart_framer_pkg::*;

  localparam int         CNT_W    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [15:0]       snap_q, snap_d;
  logic              neg_q, neg_d;
  logic [3:0]        tenths_q, tenths_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        drop_q, drop_d;

  logic [15:0]       mag;
  logic [6:0]        int_part;
  logic [7:0]        frac_x10;
  logic [3:0]        tenths_calc;
  logic              conv_start;
  logic              conv_done;
  logic [3:0]        hun, ten, uni;
  logic [7:0]        cur_byte;
  logic              unused_bits;

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == CNT_LAST);

  // Period counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sign/magnitude split of the snapshot; integer part and rounded-down tenths.
  always_comb begin
    mag         = snap_q[15] ? (~snap_q + 16'd1) : snap_q;
    int_part    = mag[10:4];
    frac_x10    = {4'd0, mag[3:0]} * 8'd10;
    tenths_calc = frac_x10[7:4];
  end

  // Bits of the magnitude and product that the frame format discards.
  assign unused_bits = ^{mag[15:11], frac_x10[3:0]};

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (int_part),
    .done_o  (conv_done),
    .hun_o   (hun),
    .ten_o   (ten),
    .uni_o   (uni)
  );

  assign cur_byte = frame_byte(idx_q, neg_q, hun, ten, uni, tenths_q);

  // Frame FSM next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    neg_d      = neg_q;
    tenths_d   = tenths_q;
    tx_data_d  = tx_data_q;
    conv_start = 1'b0;
    tx_vld     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          snap_d  = t_data;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        // A zero magnitude is always framed as positive.
        neg_d      = snap_q[15] && (mag != 16'd0);
        tenths_d   = tenths_calc;
        conv_start = 1'b1;
        idx_d      = 4'd0;
        state_d    = ST_CONV;
      end
      ST_CONV: begin
        if (conv_done) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_vld    = 1'b1;
          tx_data_d = cur_byte;
          state_d   = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SEND;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The byte appears on tx_data in its vld cycle and is held afterwards.
  assign tx_data    = tx_data_d;
  assign frame_busy = (state_q != ST_IDLE);

  // FSM state and frame datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      snap_q    <= 16'd0;
      neg_q     <= 1'b0;
      tenths_q  <= 4'd0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      neg_q     <= neg_d;
      tenths_q  <= tenths_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Any tick seen outside IDLE (including the cycle returning to IDLE) is a drop.
  always_comb begin
    drop_d = drop_q;
    if (tick && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_temp_uart_framer.sv
// Bench for temp_uart_framer: fixed frame table, random readings against a
// reference model, plus drop, reset and enable sequences.
module tb_temp_uart_framer;

  localparam int PER = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] t_data;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        frame_busy;
  logic [7:0]  drop_cnt;

  temp_uart_framer #(.PERIOD_CYC(PER)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .t_data     (t_data),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_vld     (tx_vld),
    .frame_busy (frame_busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: busy rises the cycle after vld and lasts busy_len cycles.
  int busy_len  = 20;
  int busy_left = 0;
  always @(posedge clk) begin
    if (tx_vld === 1'b1) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      tx_busy   <= 1'b0;
    end
  end

  // Byte capture, sampled mid-cycle.
  logic [7:0] vq[$];
  int         vcyc[$];
  always @(negedge clk) begin
    if (tx_vld === 1'b1) begin
      vq.push_back(tx_data);
      vcyc.push_back(cyc);
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_tot++;
    $display("FAIL %s: got no event within bound, required event", nm);
  endtask

  // Reference: frame text straight from the arithmetic definition.
  function automatic logic [71:0] model_frame(input logic [15:0] td);
    int v, mag, ip, tn;
    logic [7:0] s;
    v   = int'($signed(td));
    mag = (v < 0) ? -v : v;
    ip  = (mag / 16) % 128;
    tn  = ((mag % 16) * 10) / 16;
    s   = (v < 0 && mag != 0) ? 8'h2D : 8'h2B;
    return {s, 8'(48 + ip / 100), 8'(48 + (ip / 10) % 10), 8'(48 + ip % 10),
            8'h2E, 8'(48 + tn), 8'h43, 8'h0D, 8'h0A};
  endfunction

  task automatic run_frame(input logic [15:0] td, input bit chg,
                           output logic [71:0] got, output int nb,
                           output int rise_c, output int last_c);
    int k;
    got = '0; nb = 0; rise_c = 0; last_c = 0;
    t_data = td;
    vq.delete();
    vcyc.delete();
    k = 0;
    while (frame_busy !== 1'b1 && k < 2 * PER + 20) begin
      @(negedge clk);
      k++;
    end
    if (frame_busy !== 1'b1) begin
      timeout("frame_start");
      return;
    end
    rise_c = cyc;
    if (chg) begin
      repeat (40) @(negedge clk);
      t_data = ~td;
    end
    k = 0;
    while (frame_busy === 1'b1 && k < 9 * (busy_len + 4) + 100) begin
      last_c = cyc;
      @(negedge clk);
      k++;
    end
    if (frame_busy === 1'b1) begin
      timeout("frame_end");
      return;
    end
    nb = vq.size();
    foreach (vq[i]) got = {got[63:0], vq[i]};
    $display("frame t_data=%04h nbytes=%0d bytes=%018h drop_cnt=%0d", td, nb, got, drop_cnt);
  endtask

  typedef struct {
    logic [15:0] td;
    bit          chg;
    logic [71:0] exp;
  } vec_t;

  vec_t        tbl[5];
  logic [71:0] got;
  int          nb, rise_c, last_c, rel_c, en_c, n4, exp_drop, k;
  logic [7:0]  drop0;
  logic [15:0] td;

  initial begin
    tbl[0] = '{16'h0550, 1'b0, "+085.0C\r\n"};
    tbl[1] = '{16'hFE6F, 1'b0, "-025.0C\r\n"};
    tbl[2] = '{16'hFFF8, 1'b0, "-000.5C\r\n"};
    tbl[3] = '{16'h0000, 1'b0, "+000.0C\r\n"};
    tbl[4] = '{16'h07D0, 1'b1, "+125.0C\r\n"};

    rst = 1'b1; en = 1'b0; t_data = 16'h0000;
    #1;
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_vld", tx_vld, 1'b0);
    chk("rst_frame_busy", frame_busy, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Fixed vectors.
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].td, tbl[i].chg, got, nb, rise_c, last_c);
      chk("tbl_nbytes", nb, 9);
      chk("tbl_bytes", got, tbl[i].exp);
      chk("tx_data_hold", tx_data, 8'h0A);
    end
    chk("drop_cnt_normal", drop_cnt, 8'd0);

    // Random readings against the model.
    for (int r = 0; r < 5; r++) begin
      td = 16'($urandom);
      run_frame(td, 1'b0, got, nb, rise_c, last_c);
      chk("rand_nbytes", nb, 9);
      chk("rand_bytes", got, model_frame(td));
    end

    // Slow uart: frame overruns the period, overlapping ticks are dropped.
    busy_len = 300;
    drop0 = drop_cnt;
    td = 16'hFF5E;
    run_frame(td, 1'b0, got, nb, rise_c, last_c);
    exp_drop = 0;
    for (int t = rise_c - 1 + PER; t <= last_c; t += PER) exp_drop++;
    chk("slow_nbytes", nb, 9);
    chk("slow_bytes", got, model_frame(td));
    chk("slow_drop_cnt", int'(drop_cnt) - int'(drop0), exp_drop);
    busy_len = 20;

    // Reset in the middle of a frame.
    t_data = 16'h0550;
    vq.delete();
    vcyc.delete();
    k = 0;
    while (vq.size() < 4 && k < 3 * PER) begin
      @(negedge clk);
      k++;
    end
    if (vq.size() < 4) timeout("reset_wait_4th");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n4 = vq.size();
    chk("midrst_tx_vld", tx_vld, 1'b0);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_frame_busy", frame_busy, 1'b0);
    chk("midrst_drop_cnt", drop_cnt, 8'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rel_c = cyc;
    repeat (50) @(negedge clk);
    chk("no_vld_after_rst", vq.size(), n4);
    run_frame(16'hFE6F, 1'b0, got, nb, rise_c, last_c);
    chk("post_rst_start", rise_c - rel_c, PER);
    chk("post_rst_nbytes", nb, 9);
    chk("post_rst_bytes", got, "-025.0C\r\n");

    // Enable low: silence for three periods, then fixed latency after enabling.
    en = 1'b0;
    vq.delete();
    vcyc.delete();
    repeat (3 * PER) @(negedge clk);
    chk("en_low_no_vld", vq.size(), 0);
    chk("en_low_busy", frame_busy, 1'b0);
    t_data = 16'h0190;
    en = 1'b1;
    en_c = cyc;
    k = 0;
    while (vq.size() == 0 && k < 2 * PER) begin
      @(negedge clk);
      k++;
    end
    if (vq.size() == 0) begin
      timeout("en_first_vld");
    end else begin
      chk("en_first_vld_latency", vcyc[0] - en_c + 1, PER + 9);
      en = 1'b0;  // frame in flight must still complete
      k = 0;
      while (frame_busy === 1'b1 && k < 9 * (busy_len + 4) + 100) begin
        @(negedge clk);
        k++;
      end
      if (frame_busy === 1'b1) timeout("en_off_frame_end");
      got = '0;
      foreach (vq[i]) got = {got[63:0], vq[i]};
      $display("frame t_data=%04h nbytes=%0d bytes=%018h (en dropped mid-frame)", 16'h0190, vq.size(), got);
      chk("en_off_nbytes", vq.size(), 9);
      chk("en_off_bytes", got, "+025.0C\r\n");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/temp_uart_framer.md
TEMP_UART_FRAMER -- requirements
Module: temp_uart_framer

Interface
REQ-001 SHALL have parameter PERIOD_CYC, default 50_000_000, meaning clock cycles between frame starts (1 s at 50 MHz).
REQ-002 SHALL have parameter FRAME_LEN, default 9, meaning bytes per frame; fixed, not user-overridable.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz, the only clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  frame generation enable.
REQ-006 SHALL have port t_data  input  16  DS18B20 raw temperature: two's complement, 1/16 °C LSB.
REQ-007 SHALL have port tx_busy  input  1  high while uart_tx is shifting a byte.
REQ-008 SHALL have port tx_data  output  8  ASCII byte to uart_tx din.
REQ-009 SHALL have port tx_vld  output  1  one-cycle strobe to uart_tx din_vld.
REQ-010 SHALL have port frame_busy  output  1  high from snapshot to last byte accepted.
REQ-011 SHALL have port drop_cnt  output  8  saturating count of skipped period ticks.

Function
REQ-012 Period counter SHALL count 0..PERIOD_CYC-1 and wrap while en=1, producing tick on the wrap cycle; held at 0 while en=0.
REQ-013 States SHALL be IDLE, LATCH, CONV, SEND, WAIT_HI, WAIT_LO.
REQ-014 IDLE->LATCH on tick; LATCH snapshots t_data into an internal register, and later t_data changes SHALL NOT affect the frame.
REQ-015 LATCH SHALL compute sign = snap[15] and mag = sign ? -snap : snap (16-bit), int = mag[10:4] (0..127), tenths = (mag[3:0]*10)>>4 (truncate, 0..9).
REQ-016 CONV SHALL convert int to three BCD digits by shift-add-3 over exactly 7 cycles, then go to SEND.
REQ-017 Frame byte order SHALL be: sign ('+' 0x2B or '-' 0x2D), hundreds, tens, units (0x30+digit, leading zeros kept), '.' 0x2E, tenths digit, 'C' 0x43, CR 0x0D, LF 0x0A.
REQ-018 Zero magnitude SHALL be framed with sign '+'.
REQ-019 SEND SHALL wait for tx_busy=0, then drive tx_data with the current byte and pulse tx_vld for exactly one cycle, then go to WAIT_HI.
REQ-020 WAIT_HI SHALL wait for tx_busy=1 and then go to WAIT_LO; WAIT_LO SHALL wait for tx_busy=0, then advance the byte index.
REQ-021 After byte index 8 completes WAIT_LO, the FSM SHALL return to IDLE; otherwise it SHALL return to SEND.
REQ-022 tx_data SHALL hold its value from the tx_vld cycle until the next tx_vld.
REQ-023 A tick while frame_busy=1 SHALL be ignored and SHALL increment drop_cnt, saturating at 255.
REQ-024 Deasserting en mid-frame SHALL NOT abort the frame; only new ticks are suppressed.
REQ-025 A tick coinciding with the FSM returning to IDLE SHALL be counted as dropped, not started.
REQ-026 frame_busy SHALL be high in every non-IDLE state.
REQ-027 Latency from tick to the first tx_vld SHALL be 9 cycles when tx_busy=0 (LATCH 1, CONV 7, SEND 1).

Reset
REQ-028 On rst=1, regardless of clock, the block SHALL set FSM=IDLE, period counter=0, byte index=0, tx_data=0x00, tx_vld=0, frame_busy=0, drop_cnt=0, snapshot=0.
REQ-029 Reset mid-frame SHALL abandon the frame, emit no further tx_vld, and start the next frame only on a fresh tick after release.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the ASCII constants (0x2B, 0x2D, 0x2E, 0x43, 0x0D, 0x0A, 0x30), and FRAME_LEN.
REQ-031 The block SHALL have one sub-module, bin2bcd_seq: a 7-bit to 3-digit sequential shift-add-3 converter with start/done.

Verification
REQ-032 Run with PERIOD_CYC=2000 and a uart_tx model that raises busy one cycle after vld for 20 cycles; drive t_data=0x0550 -> bytes "+085.0C\r\n".
REQ-033 Drive t_data=0xFE6F -> "-025.0C\r\n"; drive t_data=0xFFF8 -> "-000.5C\r\n"; drive t_data=0x0000 -> "+000.0C\r\n".
REQ-034 Drive t_data=0x07D0 -> "+125.0C\r\n"; change t_data during the frame -> frame bytes unchanged.
REQ-035 With the busy model stretched to 300 cycles so the frame exceeds the period -> drop_cnt increments once per skipped tick, and the frame still contains 9 bytes.
REQ-036 Assert rst after the 4th byte -> no further tx_vld, all outputs at reset values, and the next frame is complete and starts at '+'/'-'.
REQ-037 With en=0 -> no tx_vld for 3 periods; after en=1 -> first tx_vld exactly PERIOD_CYC+9 cycles later.
